// File: rtl/calc_mem_sequencer.sv
// calc_mem_sequencer: drives one calculator operation through the core's shared data
// memory port (mailbox writes, GO flag, DONE poll, result read, flag clear, response).
module calc_mem_sequencer #(
    parameter logic [31:0] A_ADDR     = 32'h0000_0000,
    parameter logic [31:0] B_ADDR     = 32'h0000_0004,
    parameter logic [31:0] OP_ADDR    = 32'h0000_0008,
    parameter logic [31:0] FLAG_ADDR  = 32'h0000_000C,
    parameter logic [31:0] RES_ADDR   = 32'h0000_0010,
    parameter logic [31:0] GO_VALUE   = 32'd1,
    parameter logic [31:0] DONE_VALUE = 32'd2,
    parameter int          TIMEOUT    = 1024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic [31:0] EntradaCalcu,
    output logic [31:0] addressCalcu,
    output logic        writeEnableCalcu,
    input  logic [31:0] resultadoCalcu
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WR_A   = 4'd1;
    localparam logic [3:0] S_WR_B   = 4'd2;
    localparam logic [3:0] S_WR_OP  = 4'd3;
    localparam logic [3:0] S_WR_GO  = 4'd4;
    localparam logic [3:0] S_POLL   = 4'd5;
    localparam logic [3:0] S_RD_RES = 4'd6;
    localparam logic [3:0] S_CLR    = 4'd7;
    localparam logic [3:0] S_RESP   = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [31:0]   a_q, a_d, b_q, b_d, data_q, data_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = data_q;
    assign rsp_timeout = tmo_q;

    // Memory port decodes only from state and captured registers.
    always_comb begin
        state_d          = state_q;
        a_d              = a_q;
        b_d              = b_q;
        op_d             = op_q;
        data_d           = data_q;
        tmo_d            = tmo_q;
        cnt_d            = cnt_q;
        writeEnableCalcu = 1'b0;
        addressCalcu     = 32'd0;
        EntradaCalcu     = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    data_d  = 32'd0;
                    tmo_d   = 1'b0;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: begin
                writeEnableCalcu = 1'b1;
                addressCalcu     = A_ADDR;
                EntradaCalcu     = a_q;
                state_d          = S_WR_B;
            end
            S_WR_B: begin
                writeEnableCalcu = 1'b1;
                addressCalcu     = B_ADDR;
                EntradaCalcu     = b_q;
                state_d          = S_WR_OP;
            end
            S_WR_OP: begin
                writeEnableCalcu = 1'b1;
                addressCalcu     = OP_ADDR;
                EntradaCalcu     = {30'b0, op_q};
                state_d          = S_WR_GO;
            end
            S_WR_GO: begin
                writeEnableCalcu = 1'b1;
                addressCalcu     = FLAG_ADDR;
                EntradaCalcu     = GO_VALUE;
                cnt_d            = '0;
                state_d          = S_POLL;
            end
            S_POLL: begin
                addressCalcu = FLAG_ADDR;
                if (resultadoCalcu == DONE_VALUE) begin
                    state_d = S_RD_RES;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_CLR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_RES: begin
                addressCalcu = RES_ADDR;
                data_d       = resultadoCalcu;
                state_d      = S_CLR;
            end
            S_CLR: begin
                writeEnableCalcu = 1'b1;
                addressCalcu     = FLAG_ADDR;
                state_d          = S_RESP;
            end
            S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            data_q  <= 32'd0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
